// File: rtl/avalon_mm_width_down_adapter.sv
// avalon_mm_width_down_adapter: splits each wide Avalon-MM slave access into RATIO narrow master beats.
// Read beats are packed little-endian; write beats with no enabled bytes are skipped.
module avalon_mm_width_down_adapter #(
   parameter int S_DATA_W = 32,
   parameter int M_DATA_W = 16,
   parameter int ADDR_W   = 27
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     s_address,
   input  logic                  s_read,
   input  logic                  s_write,
   input  logic [S_DATA_W-1:0]   s_writedata,
   input  logic [S_DATA_W/8-1:0] s_byteenable,
   input  logic                  s_lock,
   output logic                  s_waitrequest,
   output logic [S_DATA_W-1:0]   s_readdata,
   output logic                  s_readdatavalid,
   output logic [ADDR_W-1:0]     m_address,
   output logic                  m_read,
   output logic                  m_write,
   output logic [M_DATA_W-1:0]   m_writedata,
   output logic [M_DATA_W/8-1:0] m_byteenable,
   output logic                  m_chipselect,
   output logic                  m_lock,
   input  logic                  m_waitrequest,
   input  logic [M_DATA_W-1:0]   m_readdata,
   input  logic                  m_readdatavalid
);
   localparam int RATIO = S_DATA_W / M_DATA_W;
   localparam int MB    = M_DATA_W / 8;
   localparam int BW    = $clog2(RATIO);
   localparam logic [BW-1:0] LAST = BW'(RATIO - 1);

   if (RATIO < 2 || S_DATA_W % M_DATA_W != 0 || M_DATA_W % 8 != 0) begin : g_param_check
      $error("avalon_mm_width_down_adapter: illegal width parameters");
   end

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, ACK} state_t;

   state_t            state;
   logic [BW-1:0]     beat, nxt;
   logic              req, last, rd_done, wr_done;
   logic [ADDR_W-1:0] addr_n;
   logic [MB-1:0]     be_n;
   logic [M_DATA_W-1:0] wd_n;

   assign req     = s_read | s_write;
   assign nxt     = beat + BW'(1);
   assign last    = beat == LAST;
   assign addr_n  = s_address + ADDR_W'(nxt) * ADDR_W'(MB);
   assign be_n    = s_byteenable[nxt*MB +: MB];
   assign wd_n    = s_writedata[nxt*M_DATA_W +: M_DATA_W];
   // a beat finishes when its read data arrives, or when its write is accepted or skipped
   assign rd_done = m_readdatavalid & ((state == RD_REQ & ~m_waitrequest) | state == RD_WAIT);
   assign wr_done = state == WR_REQ & (~m_write | ~m_waitrequest);

   assign s_waitrequest = req & (state != ACK);
   assign m_chipselect  = m_read | m_write;
   assign m_lock        = s_lock;

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= IDLE;
         beat            <= '0;
         m_read          <= 1'b0;
         m_write         <= 1'b0;
         m_address       <= '0;
         m_writedata     <= '0;
         m_byteenable    <= '0;
         s_readdata      <= '0;
         s_readdatavalid <= 1'b0;
      end else begin
         s_readdatavalid <= 1'b0;
         case (state)
            IDLE: begin
               beat <= '0;
               if (s_read) begin
                  state     <= RD_REQ;
                  m_read    <= 1'b1;
                  m_address <= s_address;
               end else if (s_write) begin
                  state        <= WR_REQ;
                  m_write      <= |s_byteenable[MB-1:0];
                  m_address    <= s_address;
                  m_writedata  <= s_writedata[M_DATA_W-1:0];
                  m_byteenable <= s_byteenable[MB-1:0];
               end
            end
            RD_REQ: if (!m_waitrequest) begin
               m_read <= 1'b0;
               state  <= RD_WAIT;
            end
            ACK:     state <= IDLE;
            default: ;
         endcase
         if (rd_done) begin
            s_readdata[beat*M_DATA_W +: M_DATA_W] <= m_readdata;
            if (!req) state <= IDLE;
            else if (last) begin
               state           <= ACK;
               s_readdatavalid <= 1'b1;
            end else begin
               beat      <= nxt;
               state     <= RD_REQ;
               m_read    <= 1'b1;
               m_address <= addr_n;
            end
         end
         if (wr_done) begin
            m_write <= 1'b0;
            if (!req) state <= IDLE;
            else if (last) state <= ACK;
            else begin
               beat         <= nxt;
               m_write      <= |be_n;
               m_address    <= addr_n;
               m_writedata  <= wd_n;
               m_byteenable <= be_n;
            end
         end
      end
   end
endmodule
